// File: rtl/alu_mc.sv
// Multi-cycle ALU for the tiny CPU datapath: registered result and flags, with
// iterative multiply and variable shifts behind a start/busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alus,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ZERO = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_INC  = 4'b0011,
    OP_DEC  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_NOT  = 4'b0111,
    OP_SHL1 = 4'b1000,
    OP_SHR1 = 4'b1001,
    OP_MUL  = 4'b1010,
    OP_XOR  = 4'b1011,
    OP_SHL  = 4'b1100,
    OP_SHR  = 4'b1101,
    OP_ILL0 = 4'b1110,
    OP_ILL1 = 4'b1111
  } op_t;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state, state_n;
  logic [3:0]         op_q;
  logic [CW-1:0]      cnt, cnt_init, xsat;
  logic [2*WIDTH-1:0] acc, mcand, acc_init, acc_step;
  logic [WIDTH-1:0]   mplier;
  logic               multi, load, wr_single, wr_exec;
  logic [WIDTH-1:0]   res1, res_x, res_w;
  logic               cf1, vf1, err1, cf_x, cf_w, vf_w, err_w;
  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   smin, smax;

  assign smin = {1'b1, {(WIDTH-1){1'b0}}};
  assign smax = ~smin;
  assign busy = (state == EXEC);

  // Single-cycle result and flags, straight from the inputs at the start edge.
  always_comb begin
    res1 = '0;
    cf1  = 1'b0;
    vf1  = 1'b0;
    err1 = 1'b0;
    ext  = '0;
    case (alus)
      OP_ZERO: res1 = '0;
      OP_ADD: begin
        ext  = {1'b0, bus} + {1'b0, x};
        res1 = ext[WIDTH-1:0];
        cf1  = ext[WIDTH];
        vf1  = (bus[WIDTH-1] == x[WIDTH-1]) && (ext[WIDTH-1] != bus[WIDTH-1]);
      end
      OP_SUB: begin
        ext  = {1'b0, bus} - {1'b0, x};
        res1 = ext[WIDTH-1:0];
        cf1  = ext[WIDTH];
        vf1  = (bus[WIDTH-1] != x[WIDTH-1]) && (ext[WIDTH-1] != bus[WIDTH-1]);
      end
      OP_INC: begin
        res1 = bus + 1'b1;
        cf1  = &bus;
        vf1  = (bus == smax);
      end
      OP_DEC: begin
        res1 = bus - 1'b1;
        cf1  = ~|bus;
        vf1  = (bus == smin);
      end
      OP_AND: res1 = bus & x;
      OP_OR:  res1 = bus | x;
      OP_NOT: res1 = ~bus;
      OP_XOR: res1 = bus ^ x;
      OP_SHL1: begin
        res1 = {bus[WIDTH-2:0], 1'b0};
        cf1  = bus[WIDTH-1];
      end
      OP_SHR1: begin
        res1 = {1'b0, bus[WIDTH-1:1]};
        cf1  = bus[0];
      end
      // Only x of 0 or 1 reaches the single-cycle path for variable shifts.
      OP_SHL: begin
        if (x == '0) begin
          res1 = bus;
        end else begin
          res1 = {bus[WIDTH-2:0], 1'b0};
          cf1  = bus[WIDTH-1];
        end
      end
      OP_SHR: begin
        if (x == '0) begin
          res1 = bus;
        end else begin
          res1 = {1'b0, bus[WIDTH-1:1]};
          cf1  = bus[0];
        end
      end
      OP_MUL:  res1 = '0;
      default: err1 = 1'b1;
    endcase
  end

  // Multi-cycle ops perform their first step on the start edge, so the counter
  // holds the number of remaining EXEC cycles.
  always_comb begin
    multi    = 1'b0;
    cnt_init = '0;
    acc_init = '0;
    xsat     = x[CW-1:0];
    if (x >= WIDTH'(WIDTH)) begin
      xsat = CW'(WIDTH);
    end
    case (alus)
      OP_MUL: begin
        multi    = 1'b1;
        cnt_init = CW'(WIDTH - 1);
        acc_init = x[0] ? {{WIDTH{1'b0}}, bus} : '0;
      end
      OP_SHL: begin
        multi    = |x[WIDTH-1:1];
        cnt_init = xsat - 1'b1;
        acc_init = {{WIDTH{1'b0}}, bus[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        multi    = |x[WIDTH-1:1];
        cnt_init = xsat - 1'b1;
        acc_init = {{WIDTH{1'b0}}, 1'b0, bus[WIDTH-1:1]};
      end
      default: multi = 1'b0;
    endcase
  end

  // One iteration of the latched multi-cycle op.
  always_comb begin
    acc_step = acc;
    cf_x     = 1'b0;
    case (op_q)
      OP_MUL: begin
        acc_step = mplier[0] ? (acc + mcand) : acc;
        cf_x     = |acc_step[2*WIDTH-1:WIDTH];
      end
      OP_SHL: begin
        acc_step = {{WIDTH{1'b0}}, acc[WIDTH-2:0], 1'b0};
        cf_x     = acc[WIDTH-1];
      end
      default: begin
        acc_step = {{WIDTH{1'b0}}, 1'b0, acc[WIDTH-1:1]};
        cf_x     = acc[0];
      end
    endcase
    res_x = acc_step[WIDTH-1:0];
  end

  // Next-state logic and the write strobes for the result registers.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    wr_single = 1'b0;
    wr_exec   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (multi) begin
            load    = 1'b1;
            state_n = EXEC;
          end else begin
            wr_single = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cnt == CW'(1)) begin
          wr_exec = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign res_w = wr_exec ? res_x : res1;
  assign cf_w  = wr_exec ? cf_x  : cf1;
  assign vf_w  = wr_exec ? 1'b0  : vf1;
  assign err_w = wr_exec ? 1'b0  : err1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Operand latches, iteration state and the registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      done   <= 1'b0;
      dout   <= '0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      cf     <= 1'b0;
      vf     <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= wr_single | wr_exec;
      if (wr_single | wr_exec) begin
        dout <= res_w;
        zf   <= (res_w == '0);
        nf   <= res_w[WIDTH-1];
        cf   <= cf_w;
        vf   <= vf_w;
        err  <= err_w;
      end
      if (load) begin
        op_q   <= alus;
        cnt    <= cnt_init;
        acc    <= acc_init;
        mcand  <= {{(WIDTH-1){1'b0}}, bus, 1'b0};
        mplier <= {1'b0, x[WIDTH-1:1]};
      end else if (state == EXEC) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle arithmetic logic unit for the tiny CPU datapath. It is the next generation of the combinational 8-bit ALU and keeps that ALU's 4-bit operation encoding for ops 0000–1000. It adds a WIDTH parameter, registered result and status flags, and iterative multiply and variable-shift operations. A start/busy/done handshake lets the controller stall while multi-cycle ops run. Operand `x` comes from Rs and `bus` comes from Rd, as before.

## Interface
- WIDTH, 8: datapath width; legal range ≥ 2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request an operation; sampled only when `busy` = 0.
- alus  in  4  operation select, latched with `start`.
- x  in  WIDTH  Rs operand, latched with `start`.
- bus  in  WIDTH  Rd operand, latched with `start`.
- busy  out  1  high while a multi-cycle op is executing.
- done  out  1  one-cycle pulse; `dout` and flags are valid and updated.
- dout  out  WIDTH  registered result, held until the next `done`.
- zf, nf, cf, vf  out  1 each  zero, negative, carry/borrow and signed-overflow flags, registered.
- err  out  1  set on `done` of an illegal opcode; cleared on `done` of any legal op.

## Operation
- Opcodes (b = bus, a = x):
  - 0000: 0
  - 0001: b+a
  - 0010: b−a
  - 0011: b+1
  - 0100: b−1
  - 0101: b&a
  - 0110: b|a
  - 0111: ~b
  - 1000: b<<1
  - 1001: b>>1 (logical)
  - 1010: b*a, low WIDTH bits (iterative shift-add)
  - 1011: b^a
  - 1100: b<<a (iterative)
  - 1101: b>>a (iterative, logical)
  - 1110, 1111: illegal; result 0, err=1
- Arithmetic is modulo 2^WIDTH.
- Shift amount is the full `x` value. The op iterates min(x, WIDTH) single-bit steps, so x ≥ WIDTH yields 0. x=0 returns b unchanged.
- States:
  - IDLE: `start` with a single-cycle op (every op except 1010, and 1100/1101 when x ≤ 1) computes the result at that edge; `done` is high the next cycle; the state stays IDLE.
  - IDLE: `start` with 1010, or with 1100/1101 when x ≥ 2, latches operands, loads the iteration counter and enters EXEC.
  - EXEC: one iteration per cycle. On the final iteration, write `dout`/flags, pulse `done` and return to IDLE.
- `busy` = (state == EXEC). `start` is ignored while `busy` = 1 (no queueing). `start` is accepted in the same cycle that `done` is high.
- Flags are written only when `done` is asserted; otherwise they hold.
  - zf = (result == 0); nf = result[WIDTH-1].
  - cf by op:
    - add: carry out
    - sub: borrow (b < a)
    - inc: b = all ones
    - dec: b = 0
    - shl1 / shl-by-a: last bit shifted out of the MSB
    - shr1 / shr-by-a: last bit shifted out of the LSB
    - mul: high half of the 2·WIDTH product ≠ 0
    - shift with a = 0, and all other ops: 0
  - vf: add/sub signed overflow; inc with b = 0111…1; dec with b = 1000…0; otherwise 0.
- Reset (asynchronous, also mid-operation): state IDLE; counter, `dout`, all flags, `err`, `busy` and `done` go to 0. A partial result is discarded and `done` is never produced for it.

## Timing
- Latency N is counted from the cycle `start` is sampled to the cycle `done` is high:
  - single-cycle ops: N = 1
  - mul: N = WIDTH
  - shift-by-x: N = max(1, min(x, WIDTH))
- `busy` rises in the cycle after a multi-cycle start and falls in the cycle `done` is high.
- `dout` changes only in the `done` cycle. It is stable from there until the next `done`.
- Back-to-back: `start` held high continuously issues a new op every N cycles with no gap.
- Operand inputs may change freely after the start cycle without affecting the result.

## Test plan
- WIDTH=8; add 0xFF+0x01 -> `done` 1 cycle later, dout=0x00, zf=1, cf=1, vf=0, nf=0.
- sub b=0x80, a=0x01 -> dout=0x7F, vf=1, cf=0. Then dec b=0x00 -> dout=0xFF, cf=1, nf=1.
- mul b=0x0F, a=0x11 -> `busy` high 7 cycles, `done` at cycle 8, dout=0xFF, cf=0. Then b=0x10, a=0x10 -> dout=0x00, zf=1, cf=1.
- shl b=0x81 by a=3 -> `done` at cycle 3, dout=0x08, cf=0. shr b=0x81 by a=9 -> `done` at cycle 8, dout=0x00, zf=1.
- Pulse `start` (add) during a mul -> ignored; the mul result is unchanged and only one `done` fires. Assert `rst` mid-mul -> all outputs 0 immediately, no `done`. The next add works normally.
- alus=1111 -> `done` after 1 cycle, dout=0, err=1. The following legal op clears err. Repeat the key cases at WIDTH=16.
